ser_meter: RTL and testbench
============================

// Module: ser_meter
// PURPOSE
//   Parametrised symbol-error-rate meter for the M-ary link test chain; replaces the fixed 2-bit comparator.
//   Compares the transmitted symbol stream (LFSR symbols) with the slicer output at symbol rate.
//   Auto-aligns for the unknown TX->RX pipeline delay, then counts errors over a fixed window.
//   Latches the results for readout.
// PARAMETERS
//   SYM_W        2    symbol width in bits (2 = 4-ASK)
//   MAX_DELAY    16   number of candidate alignment delays, 0..MAX_DELAY-1
//   DLY_W        4    width of delay_sel; must satisfy 2**DLY_W >= MAX_DELAY
//   ALIGN_LEN    32   consecutive matches required to declare lock
//   WINDOW_LOG2  22   measurement window = 2**WINDOW_LOG2 symbols
//   CNT_W        23   counter width = WINDOW_LOG2+1, so it holds 2**WINDOW_LOG2 exactly
// PORTS
//   sys_clk      in   1      system clock; all logic on posedge
//   reset        in   1      synchronous, active-high
//   sym_clk_ena  in   1      symbol-rate enable; all comparisons/shifts only on these cycles
//   start        in   1      pulse; begins a measurement from IDLE or DONE
//   ref_sym      in   SYM_W  transmitted symbol
//   rx_sym       in   SYM_W  sliced received symbol
//   busy         out  1      high in FILL/ALIGN/MEASURE
//   done         out  1      high (level) in DONE
//   locked       out  1      alignment found; valid while busy or done
//   delay_sel    out  DLY_W  current/chosen alignment delay in symbols
//   err_count    out  CNT_W  symbol errors in window
//   sym_count    out  CNT_W  symbols compared in window
//   sym_error    out  1      one-sys_clk pulse per mismatched symbol in MEASURE
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; delay line cleared. Applies in any state, including mid-measurement.
//   Delay line: MAX_DELAY-deep shift of ref_sym.
//     - Shifts on every sym_clk_ena, in every state.
//     - tap[d] = ref_sym from d symbol ticks earlier; tap[0] = current ref_sym.
//   mismatch = (rx_sym != tap[delay_sel]), evaluated only on sym_clk_ena cycles.
//   FSM (transitions and counter updates on sym_clk_ena unless noted):
//     IDLE:    start (any cycle) -> FILL.
//              On entry to FILL: delay_sel=0, locked=0, err_count=0, sym_count=0, fill/trial counters=0.
//     FILL:    count MAX_DELAY symbol ticks -> ALIGN. No comparisons.
//     ALIGN:   trial counter increments on match.
//              - On mismatch with delay_sel<MAX_DELAY-1: delay_sel++, trial counter=0.
//                That symbol ends the trial; the next symbol starts the new trial.
//              - On mismatch with delay_sel==MAX_DELAY-1: -> DONE, locked=0, counts stay 0.
//              - Trial counter reaches ALIGN_LEN: locked=1 -> MEASURE; delay_sel frozen.
//     MEASURE: per tick: sym_count++, err_count += mismatch, sym_error pulses on mismatch.
//              sym_count reaching 2**WINDOW_LOG2 -> DONE.
//              err_count <= sym_count always, so no saturation is needed.
//     DONE:    done=1; counts, locked and delay_sel held. start -> FILL (re-arm, clears as above).
//   start while busy is ignored; reset is the only abort.
//   start coincident with sym_clk_ena: the transition wins and that symbol is not counted.
//     The delay line still shifts.
//   Latency: counters, sym_error, state and delay_sel update on the sys_clk edge that samples sym_clk_ena.
//     They are visible 1 sys_clk later.
//   Counter updates and DONE entry occur on the same edge (final symbol counted).
//   Known limit: periodic or constant ref patterns may lock at an alias delay; the bench uses an LFSR source.
// TESTING  (sim params: MAX_DELAY=8, DLY_W=3, ALIGN_LEN=8, WINDOW_LOG2=6, CNT_W=7; ena every 4 clks)
//   1 reset held 3 clks, then released -> all outputs 0, busy=0; start ignored during reset.
//   2 rx = LFSR ref delayed 3 symbols, start -> locked=1, delay_sel=3, done; sym_count=64, err_count=0.
//   3 delay 5, flip rx on every 16th MEASURE symbol -> delay_sel=5, err_count=4, 4 sym_error pulses.
//   4 rx_sym held at 0 -> all 8 trials fail; done=1, locked=0, delay_sel=7, counts 0.
//   5 reset pulsed mid-MEASURE (sym_count=20) -> next clk busy=0, counts 0; restart relocks to same delay.
//   6 start on an ena cycle and start while busy -> first symbol not counted; second start ignored; 64 counted.

Source files
------------

// File: rtl/ser_meter.sv
// Symbol-error-rate meter: aligns the received symbol stream against a delayed
// copy of the reference stream, then counts symbol errors over a fixed window.
module ser_meter #(
    parameter int SYM_W       = 2,
    parameter int MAX_DELAY   = 16,
    parameter int DLY_W       = 4,
    parameter int ALIGN_LEN   = 32,
    parameter int WINDOW_LOG2 = 22,
    parameter int CNT_W       = 23
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sym_clk_ena,
    input  logic             start,
    input  logic [SYM_W-1:0] ref_sym,
    input  logic [SYM_W-1:0] rx_sym,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic [DLY_W-1:0] delay_sel,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sym_count,
    output logic             sym_error
);

    localparam int FILL_W  = $clog2(MAX_DELAY) + 1;
    localparam int TRIAL_W = $clog2(ALIGN_LEN) + 1;

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(MAX_DELAY - 1);
    localparam logic [TRIAL_W-1:0] TRIAL_LAST = TRIAL_W'(ALIGN_LEN - 1);
    localparam logic [DLY_W-1:0]   DLY_LAST   = DLY_W'(MAX_DELAY - 1);
    localparam logic [CNT_W-1:0]   WIN_LAST   = CNT_W'((64'd1 << WINDOW_LOG2) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ALIGN,
        MEASURE,
        DONE
    } state_t;

    state_t               state;
    logic [FILL_W-1:0]    fill_cnt;
    logic [TRIAL_W-1:0]   trial_cnt;
    logic [SYM_W-1:0]     dline [1:MAX_DELAY-1];
    logic [SYM_W-1:0]     taps  [MAX_DELAY];
    logic                 mismatch;

    // tap 0 is the live reference symbol; deeper taps come from the shift register
    always_comb begin
        taps[0] = ref_sym;
        for (int d = 1; d < MAX_DELAY; d++) begin
            taps[d] = dline[d];
        end
        mismatch = (rx_sym != taps[delay_sel]);
    end

    assign busy = (state == FILL) || (state == ALIGN) || (state == MEASURE);
    assign done = (state == DONE);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            trial_cnt <= '0;
            locked    <= 1'b0;
            delay_sel <= '0;
            err_count <= '0;
            sym_count <= '0;
            sym_error <= 1'b0;
            for (int d = 1; d < MAX_DELAY; d++) begin
                dline[d] <= '0;
            end
        end else begin
            sym_error <= 1'b0;

            // the delay line runs in every state so the taps are always history
            if (sym_clk_ena) begin
                dline[1] <= ref_sym;
                for (int d = 2; d < MAX_DELAY; d++) begin
                    dline[d] <= dline[d-1];
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= FILL;
                        fill_cnt  <= '0;
                        trial_cnt <= '0;
                        locked    <= 1'b0;
                        delay_sel <= '0;
                        err_count <= '0;
                        sym_count <= '0;
                    end
                end
                FILL: begin
                    if (sym_clk_ena) begin
                        if (fill_cnt == FILL_LAST) begin
                            state <= ALIGN;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                end
                ALIGN: begin
                    // a mismatching symbol ends the trial; the next symbol opens the new one
                    if (sym_clk_ena) begin
                        if (mismatch) begin
                            if (delay_sel == DLY_LAST) begin
                                state  <= DONE;
                                locked <= 1'b0;
                            end else begin
                                delay_sel <= delay_sel + DLY_W'(1);
                                trial_cnt <= '0;
                            end
                        end else if (trial_cnt == TRIAL_LAST) begin
                            locked <= 1'b1;
                            state  <= MEASURE;
                        end else begin
                            trial_cnt <= trial_cnt + TRIAL_W'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (sym_clk_ena) begin
                        sym_count <= sym_count + CNT_W'(1);
                        err_count <= err_count + {{(CNT_W-1){1'b0}}, mismatch};
                        sym_error <= mismatch;
                        if (sym_count == WIN_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_meter.sv
// Self-checking bench for ser_meter: LFSR reference stream, delayed/corrupted rx
// stream, expected measurement results queued at start and checked at done.
module tb_ser_meter;

    localparam int SYM_W       = 2;
    localparam int MAX_DELAY   = 8;
    localparam int DLY_W       = 3;
    localparam int ALIGN_LEN   = 8;
    localparam int WINDOW_LOG2 = 6;
    localparam int CNT_W       = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             sym_clk_ena;
    logic             start;
    logic [SYM_W-1:0] ref_sym;
    logic [SYM_W-1:0] rx_sym;
    logic             busy;
    logic             done;
    logic             locked;
    logic [DLY_W-1:0] delay_sel;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sym_count;
    logic             sym_error;

    ser_meter #(
        .SYM_W(SYM_W),
        .MAX_DELAY(MAX_DELAY),
        .DLY_W(DLY_W),
        .ALIGN_LEN(ALIGN_LEN),
        .WINDOW_LOG2(WINDOW_LOG2),
        .CNT_W(CNT_W)
    ) dut (
        .sys_clk(clk),
        .reset(reset),
        .sym_clk_ena(sym_clk_ena),
        .start(start),
        .ref_sym(ref_sym),
        .rx_sym(rx_sym),
        .busy(busy),
        .done(done),
        .locked(locked),
        .delay_sel(delay_sel),
        .err_count(err_count),
        .sym_count(sym_count),
        .sym_error(sym_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int dly;
        int lck;
        int errs;
        int syms;
        int pulses;
    } result_t;

    result_t    sb[$];
    int         vectors     = 0;
    int         miscompares = 0;

    logic [15:0] lfsr = 16'hACE1;
    logic [1:0]  hist [0:15];
    int          phase     = 0;
    int          tick      = 0;
    int          tx_delay  = 0;
    bit          rx_zero   = 0;
    bit          flip_on   = 0;
    int          meas_idx  = 0;
    int          err_pulses = 0;
    bit          done_seen = 0;
    bit          lock_seen = 0;
    int          done_tick = 0;
    int          lock_tick = 0;
    int          start_tick = 0;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One sys_clk step: sample outputs at the negedge, then drive the next inputs.
    task automatic applyStimulus(input logic st, input logic rs);
        logic [1:0] sym;
        @(negedge clk);
        if (sym_error) err_pulses++;
        if (done && !done_seen) begin
            done_seen = 1;
            done_tick = tick;
        end
        if (locked && !lock_seen) begin
            lock_seen = 1;
            lock_tick = tick;
        end
        phase = (phase + 1) % 4;
        sym_clk_ena = (phase == 0);
        if (sym_clk_ena) begin
            tick++;
            for (int s = 0; s < 2; s++) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
            for (int i = 15; i > 0; i--) begin
                hist[i] = hist[i-1];
            end
            hist[0] = lfsr[1:0];
            ref_sym = hist[0];
            sym = rx_zero ? 2'b00 : hist[tx_delay];
            if (busy && locked) begin
                if (flip_on && (meas_idx % 16 == 15)) sym = ~sym;
                meas_idx++;
            end
            rx_sym = sym;
        end
        start = st;
        reset = rs;
    endtask

    task automatic pushExpected(input int id, input int dly, input int lck,
                                input int errs, input int syms, input int pulses);
        result_t r;
        r.id = id; r.dly = dly; r.lck = lck; r.errs = errs; r.syms = syms; r.pulses = pulses;
        sb.push_back(r);
    endtask

    // Issue a start pulse either coincident with a symbol tick or between ticks.
    task automatic startMeasure(input bit on_ena);
        if (on_ena) begin
            while (phase != 3) applyStimulus(1'b0, 1'b0);
        end else begin
            while (phase == 3) applyStimulus(1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0);
        start_tick = tick;
        done_seen  = 0;
        lock_seen  = 0;
        err_pulses = 0;
        meas_idx   = 0;
    endtask

    task automatic waitDone();
        result_t r;
        int guard = 0;
        while (!done_seen && guard < 4000) begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
        r = sb.pop_front();
        checkOutput($sformatf("t%0d_done", r.id), longint'(done_seen), 1);
        checkOutput($sformatf("t%0d_busy", r.id), busy, 0);
        checkOutput($sformatf("t%0d_delay_sel", r.id), delay_sel, r.dly);
        checkOutput($sformatf("t%0d_locked", r.id), locked, r.lck);
        checkOutput($sformatf("t%0d_err_count", r.id), err_count, r.errs);
        checkOutput($sformatf("t%0d_sym_count", r.id), sym_count, r.syms);
        checkOutput($sformatf("t%0d_sym_error_pulses", r.id), err_pulses, r.pulses);
    endtask

    task automatic runUntilMeas(input int target, input string tag);
        int guard = 0;
        while (meas_idx < target && guard < 4000) begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
        if (meas_idx < target) checkOutput(tag, meas_idx, target);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sym_clk_ena = 1'b0;
        ref_sym = '0;
        rx_sym = '0;
        for (int i = 0; i < 16; i++) hist[i] = 2'b00;

        // Test 1: reset for 3 clocks with a start pulse during reset
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_done", done, 0);
        checkOutput("t1_locked", locked, 0);
        checkOutput("t1_delay_sel", delay_sel, 0);
        checkOutput("t1_err_count", err_count, 0);
        checkOutput("t1_sym_count", sym_count, 0);
        checkOutput("t1_sym_error", sym_error, 0);

        // Test 2: clean link, 3-symbol delay
        tx_delay = 3;
        pushExpected(2, 3, 1, 0, 64, 0);
        startMeasure(1'b0);
        waitDone();

        // Test 3: 5-symbol delay with every 16th measured symbol corrupted
        tx_delay = 5;
        flip_on = 1;
        pushExpected(3, 5, 1, 4, 64, 4);
        startMeasure(1'b0);
        waitDone();
        flip_on = 0;

        // Test 4: dead receiver, every candidate delay fails
        rx_zero = 1;
        pushExpected(4, 7, 0, 0, 0, 0);
        startMeasure(1'b0);
        waitDone();
        rx_zero = 0;

        // Test 5: reset in the middle of a measurement, then relock
        tx_delay = 5;
        startMeasure(1'b0);
        runUntilMeas(20, "t5_reach_20");
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5_mid_sym_count", sym_count, 20);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_locked", locked, 0);
        checkOutput("t5_rst_delay_sel", delay_sel, 0);
        checkOutput("t5_rst_err_count", err_count, 0);
        checkOutput("t5_rst_sym_count", sym_count, 0);
        pushExpected(5, 5, 1, 0, 64, 0);
        startMeasure(1'b0);
        waitDone();

        // Test 6: start coincident with a symbol tick, then a start while busy
        tx_delay = 0;
        pushExpected(6, 0, 1, 0, 64, 0);
        startMeasure(1'b1);
        runUntilMeas(10, "t6_reach_10");
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6_mid_sym_count", sym_count, 10);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6_busy_after_start", busy, 1);
        checkOutput("t6_locked_after_start", locked, 1);
        checkOutput("t6_sym_count_after_start", sym_count, 10);
        waitDone();
        checkOutput("t6_ticks_to_lock", lock_tick - start_tick, 16);
        checkOutput("t6_ticks_to_done", done_tick - start_tick, 80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
